nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-precision adder sequencer placed directly upstream of the 4-bit carry-skip adder stage.
//  Accepts two WIDTH-bit operands through a valid/ready handshake.
//  Feeds one 4-bit nibble pair per cycle, LSB nibble first, into a 4-bit carry-skip slice.
//  Registers the slice carry between cycles and assembles the WIDTH-bit sum.
//  Presents the result on a valid/ready output. Trades latency for area in wide datapaths.
// PARAMETERS
//  WIDTH  16  operand/sum width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operand pair a/b/cin valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry into nibble 0
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  A+B+cin, low WIDTH bits
//  cout       out  1      carry out of MSB nibble
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset rst_n is synchronous and active-low.
//  - Reset values: state=IDLE, nibble index=0, carry=0. sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
//  - Let N=WIDTH/4. FSM states: IDLE, RUN, DONE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid&in_ready, register a, b; carry<=cin; idx<=0; sum<=0; go to RUN.
//  - RUN:
//    - in_ready=0.
//    - Each cycle: slice computes a[4idx+:4] + b[4idx+:4] + carry.
//    - sum[4idx+:4]<=slice sum; carry<=slice cout; idx<=idx+1.
//    - At idx==N-1: cout<=slice cout; go to DONE.
//  - DONE:
//    - out_valid=1; sum/cout held stable while out_ready=0.
//    - On out_ready, go to IDLE (out_valid drops next cycle).
//  - Latency: an operand accepted at edge T occupies RUN for N cycles. out_valid is first high after edge T+N.
//  - Throughput: one operation per N+2 cycles at best.
//  - No overlap: in_ready is registered state only (IDLE). No combinational path from out_ready to in_ready.
//  - WIDTH=4: RUN lasts exactly one cycle.
//  - Overflow: addition is modulo 2^WIDTH; the overflow carry appears only on cout.
//  - in_valid while busy: ignored; the operand must be held by the producer.
//  - rst_n low in any state (including mid-RUN): aborts the operation next edge, all outputs return to reset values, partial sum discarded.
// CONFIGURATION
//  - Macro SKIP_COUNT_EN defined:
//    - Adds output skip_cnt [$clog2(N+1)] = number of nibbles whose propagate (a^b) was all ones in the last operation.
//    - Cleared on accept and on reset; valid with out_valid.
//  - Macro SKIP_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package: state enum {IDLE,RUN,DONE}; NIBBLE_W=4 constant.
//  - One sub-module: cskip_slice4, the 4-bit ripple + skip-mux adder (inputs a,b,cin; outputs s,cout,skip).
//  - Instantiated once. Its skip output feeds the optional counter.
// TESTING (WIDTH=16)
//  - 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0. out_valid first high 4 cycles after accept edge. skip_cnt=0.
//  - 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1. skip_cnt=3.
//  - 0x0F0F+0xF0F0, cin=1 -> sum=0x0000, cout=1. skip_cnt=4 (full bypass chain).
//  - Hold out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0. Second in_valid meanwhile is not accepted.
//  - rst_n=0 during the 2nd RUN cycle -> next cycle out_valid=0, sum=0, in_ready=1. A new op then computes correctly.
//  - Back-to-back ops with out_ready tied high -> accepts spaced exactly N+2=6 cycles apart.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional feature macro: SKIP_COUNT_EN (per-operation skip counter).
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of nibble beats needed to cover a given operand width.
    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cskip_slice4.sv
// 4-bit ripple adder with a carry-skip mux on the group carry.
// skip flags a fully propagating nibble (a^b all ones).
module cskip_slice4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                skip
);

    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Ripple chain inside the nibble.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]   = p[i] ^ c[i];
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    // A fully propagating nibble forwards cin straight to cout.
    assign skip = &p;
    assign cout = skip ? cin : c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision adder: feeds one nibble pair per cycle into a
// carry-skip slice. Optional macro SKIP_COUNT_EN adds skip_cnt.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SKIP_COUNT_EN
    ,
    output logic [$clog2(WIDTH/NIBBLE_W+1)-1:0] skip_cnt
`endif
);

    localparam int N     = nibble_count(WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and >= 4");
    end

    logic [1:0]       state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;
    logic                slice_skip;

    // Select the nibble pair addressed by the beat index.
    always_comb begin
        nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
    end

    cskip_slice4 u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co),
        .skip (slice_skip)
    );

    // Sequencer: accept, walk N nibbles, then hold the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= slice_s;
                    carry_q <= slice_co;
                    if (idx_q == LAST) begin
                        cout_q  <= slice_co;
                        idx_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

`ifdef SKIP_COUNT_EN
    logic [$clog2(N+1)-1:0] skip_cnt_q;

    // Count fully propagating nibbles of the current operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skip_cnt_q <= '0;
        end else if (state_q == ST_IDLE && in_valid) begin
            skip_cnt_q <= '0;
        end else if (state_q == ST_RUN && slice_skip) begin
            skip_cnt_q <= skip_cnt_q + 1'b1;
        end
    end

    assign skip_cnt = skip_cnt_q;
`else
    logic unused_skip;
    assign unused_skip = slice_skip;
`endif

endmodule
